mux4_rr_sequencer: RTL

- Round-robin sequencer sitting directly upstream of the 4-way, 4-bit word multiplexer.
- Arbitrates among four requesting sources and drives the multiplexer's 2-bit select.
- Captures the multiplexer's output word one cycle after select is stable.
- Presents the captured word downstream on a valid/ready handshake, and pulses a one-hot grant back to the winning source.

---
 rtl/mux4_rr_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mux4_rr_sequencer.sv
// Round-robin sequencer in front of a 4:1 word multiplexer: it picks a requester,
// drives the select, captures the muxed word and offers it on a valid/ready output.
module mux4_rr_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RR_INIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_i,
  output logic [1:0]       sel_o,
  input  logic [WIDTH-1:0] mux_y_i,
  output logic [3:0]       gnt_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       out_chan_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       last_q, last_d;
  logic             busy_q, busy_d;

  logic [1:0]       win_idx;
  logic             win_found;
  logic             handshake;

  assign handshake = out_valid_q & out_ready_i;

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    logic [1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = last_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      gnt_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 2'(RR_INIT);
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (win_found) state_d = ST_SELECT;
      ST_SELECT: state_d = ST_HOLD;
      ST_HOLD:   if (handshake) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; gnt defaults low so it pulses for one cycle.
  always_comb begin
    sel_d       = sel_q;
    gnt_d       = '0;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) sel_d = win_idx;
      end
      ST_SELECT: begin
        out_data_d  = mux_y_i;
        out_chan_d  = sel_q;
        out_valid_d = 1'b1;
        gnt_d       = 4'(4'b0001 << sel_q);
        last_d      = sel_q;
      end
      ST_HOLD: begin
        if (handshake) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign sel_o       = sel_q;
  assign gnt_o       = gnt_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;

endmodule
